elixirchip_es1_spu_op_lut_rsearch: RTL and testbench

ELIXIRCHIP_ES1_SPU_OP_LUT_RSEARCH -- requirements
Module: elixirchip_es1_spu_op_lut_rsearch

---
 rtl/elixirchip_es1_spu_op_lut_rsearch.sv | 143 ++++++++++++++
 tb/tb_elixirchip_es1_spu_op_lut_rsearch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/elixirchip_es1_spu_op_lut_rsearch.sv
// ---------------------------------------------------------------------------
// elixirchip_es1_spu_op_lut_rsearch
//
// Purpose:
//   Sequential reverse lookup in a constant table. A search key is accepted,
//   then the table is walked from address 0 upward, one entry per enabled
//   clock. The block reports the lowest address whose entry equals the key,
//   or NOT_FOUND_ADDR when the key is absent. Only one search runs at a time.
//
// Ports:
//   reset    in   synchronous active-high reset, priority over cke
//   clk      in   clock, rising edge
//   cke      in   clock enable; low freezes all state and outputs
//   s_data   in   [DATA_BITS-1:0] search key
//   s_valid  in   key valid
//   s_ready  out  key accepted when s_valid && s_ready && cke (state only)
//   m_addr   out  [ADDR_BITS-1:0] matching address or NOT_FOUND_ADDR
//   m_found  out  1 = match found
//   m_valid  out  result valid (state only)
//   m_ready  in   result consumed when m_valid && m_ready && cke
// ---------------------------------------------------------------------------
module elixirchip_es1_spu_op_lut_rsearch #(
    parameter int                               TABLE_SIZE     = 64,
    parameter int                               ADDR_BITS      = $clog2(TABLE_SIZE),
    parameter int                               DATA_BITS      = 8,
    parameter logic [TABLE_SIZE*DATA_BITS-1:0]  TABLE_VALUES   = '0,
    parameter logic [ADDR_BITS-1:0]             NOT_FOUND_ADDR = '0,
    parameter                                   DEVICE         = "RTL",
    parameter                                   SIMULATION     = "false",
    parameter                                   DEBUG          = "false"
) (
    input  logic                    reset,
    input  logic                    clk,
    input  logic                    cke,

    input  logic [DATA_BITS-1:0]    s_data,
    input  logic                    s_valid,
    output logic                    s_ready,

    output logic [ADDR_BITS-1:0]    m_addr,
    output logic                    m_found,
    output logic                    m_valid,
    input  logic                    m_ready
);

    localparam int IDX_BITS = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1;
    localparam logic [IDX_BITS-1:0] LAST_INDEX = IDX_BITS'(TABLE_SIZE - 1);

    // Implementation-selection parameters carry no function in this RTL model.
    if (DEVICE == "" && SIMULATION == "" && DEBUG == "") begin : g_no_function_params
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [IDX_BITS-1:0]    r_index;
    logic [DATA_BITS-1:0]   r_key;
    logic [ADDR_BITS-1:0]   r_addr;
    logic                   r_found;
    logic                   r_s_ready;
    logic                   r_m_valid;

    logic [DATA_BITS-1:0]   w_entry;
    logic                   w_match;
    logic                   w_last;

    // Table entry under the scan pointer and its comparison against the key.
    always_comb begin
        w_entry = TABLE_VALUES[r_index*DATA_BITS +: DATA_BITS];
        w_match = (w_entry == r_key);
        w_last  = (r_index == LAST_INDEX);
    end

    // Search FSM; handshake flags are registered alongside the state so that
    // s_ready and m_valid never depend combinationally on s_valid / m_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_index   <= '0;
            r_key     <= '0;
            r_addr    <= NOT_FOUND_ADDR;
            r_found   <= 1'b0;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
        end else if (cke) begin
            case (r_state)
                ST_IDLE: begin
                    if (s_valid) begin
                        r_key     <= s_data;
                        r_index   <= '0;
                        r_state   <= ST_SCAN;
                        r_s_ready <= 1'b0;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (w_match) begin
                        r_addr    <= ADDR_BITS'(r_index);
                        r_found   <= 1'b1;
                        r_state   <= ST_DONE;
                        r_m_valid <= 1'b1;
                    end else if (w_last) begin
                        // Pointer stops here; it never wraps past the table end.
                        r_addr    <= NOT_FOUND_ADDR;
                        r_found   <= 1'b0;
                        r_state   <= ST_DONE;
                        r_m_valid <= 1'b1;
                    end else begin
                        r_index   <= r_index + IDX_BITS'(1);
                    end
                end
                ST_DONE: begin
                    if (m_ready) begin
                        r_state   <= ST_IDLE;
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                    end else begin
                        r_state   <= ST_DONE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_index   <= '0;
                    r_s_ready <= 1'b1;
                    r_m_valid <= 1'b0;
                end
            endcase
        end else begin
            r_state <= r_state;
        end
    end

    assign s_ready = r_s_ready;
    assign m_valid = r_m_valid;
    assign m_addr  = r_addr;
    assign m_found = r_found;

endmodule

// File: tb/tb_elixirchip_es1_spu_op_lut_rsearch.sv
// ---------------------------------------------------------------------------
// tb_elixirchip_es1_spu_op_lut_rsearch
//
// Two instances: A holds an identity table (entry i = i) with a non-zero
// not-found address; B holds 0x55 at addresses 5 and 9, zero elsewhere,
// with the default not-found address. Directed vectors with hand-computed
// address / found / latency, followed by back-pressure, reset-abort and a
// random clock-enable run against a simple reference rule.
// ---------------------------------------------------------------------------
module tb_elixirchip_es1_spu_op_lut_rsearch;

    localparam logic [5:0] NF_A = 6'd42;

    function automatic logic [511:0] mk_id();
        logic [511:0] t;
        t = '0;
        for (int i = 0; i < 64; i++) t[i*8 +: 8] = 8'(i);
        return t;
    endfunction

    localparam logic [511:0] ID_TBL  = mk_id();
    localparam logic [511:0] DUP_TBL = (512'h55 << 40) | (512'h55 << 72);

    logic       clk;
    logic       reset;
    logic       cke;
    logic [7:0] s_data;
    logic       s_valid_a;
    logic       s_valid_b;
    logic       m_ready;

    logic       a_s_ready, a_m_found, a_m_valid;
    logic [5:0] a_m_addr;
    logic       b_s_ready, b_m_found, b_m_valid;
    logic [5:0] b_m_addr;

    int checks;
    int failures;

    elixirchip_es1_spu_op_lut_rsearch #(
        .TABLE_SIZE     (64),
        .DATA_BITS      (8),
        .TABLE_VALUES   (ID_TBL),
        .NOT_FOUND_ADDR (NF_A)
    ) u_dut_a (
        .reset   (reset),
        .clk     (clk),
        .cke     (cke),
        .s_data  (s_data),
        .s_valid (s_valid_a),
        .s_ready (a_s_ready),
        .m_addr  (a_m_addr),
        .m_found (a_m_found),
        .m_valid (a_m_valid),
        .m_ready (m_ready)
    );

    elixirchip_es1_spu_op_lut_rsearch #(
        .TABLE_SIZE   (64),
        .DATA_BITS    (8),
        .TABLE_VALUES (DUP_TBL)
    ) u_dut_b (
        .reset   (reset),
        .clk     (clk),
        .cke     (cke),
        .s_data  (s_data),
        .s_valid (s_valid_b),
        .s_ready (b_s_ready),
        .m_addr  (b_m_addr),
        .m_found (b_m_found),
        .m_valid (b_m_valid),
        .m_ready (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One complete search on instance A (sel_b=0) or B (sel_b=1).
    task automatic do_search(input logic sel_b, input logic [7:0] key,
                             input logic [5:0] ea, input logic ef, input int el,
                             input logic rnd, input logic wait_idle);
        int  lat;
        bit  c;
        bit  got;
        chk("ready_before_accept", 32'(sel_b ? b_s_ready : a_s_ready), 32'd1);
        s_data = key;
        if (sel_b) s_valid_b = 1'b1; else s_valid_a = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(posedge clk);
            c = cke;
            #1;
            if (rnd) cke = ($urandom_range(0, 9) != 0);
            if (c) got = 1'b1;
        end
        s_valid_a = 1'b0;
        s_valid_b = 1'b0;
        s_data    = ~key;   // must not disturb the search in flight
        chk("accept_timeout", 32'(got), 32'd1);
        lat = 0;
        got = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(posedge clk);
            c = cke;
            #1;
            if (rnd) cke = ($urandom_range(0, 9) != 0);
            if (c) lat++;
            if (sel_b ? b_m_valid : a_m_valid) got = 1'b1;
        end
        chk("result_timeout", 32'(got), 32'd1);
        chk("latency", 32'(lat), 32'(el));
        chk("m_addr", 32'(sel_b ? b_m_addr : a_m_addr), 32'(ea));
        chk("m_found", 32'(sel_b ? b_m_found : a_m_found), 32'(ef));
        if (wait_idle) begin
            got = 1'b0;
            for (int n = 0; n < 100 && !got; n++) begin
                @(posedge clk);
                #1;
                if (rnd) cke = ($urandom_range(0, 9) != 0);
                if ((sel_b ? b_s_ready : a_s_ready) && !(sel_b ? b_m_valid : a_m_valid)) got = 1'b1;
            end
            chk("return_idle", 32'(got), 32'd1);
        end
    endtask

    typedef struct {
        logic       sel_b;
        logic [7:0] key;
        logic [5:0] ea;
        logic       ef;
        int         el;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [7:0] k;
        bit         seen;

        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        cke       = 1'b1;
        s_data    = 8'h00;
        s_valid_a = 1'b0;
        s_valid_b = 1'b0;
        m_ready   = 1'b1;

        vecs[0] = '{1'b0, 8'h00, 6'd0,  1'b1, 1};
        vecs[1] = '{1'b0, 8'h3F, 6'd63, 1'b1, 64};
        vecs[2] = '{1'b0, 8'h80, NF_A,  1'b0, 64};
        vecs[3] = '{1'b0, 8'h15, 6'd21, 1'b1, 22};
        vecs[4] = '{1'b0, 8'hFF, NF_A,  1'b0, 64};
        vecs[5] = '{1'b0, 8'h40, NF_A,  1'b0, 64};
        vecs[6] = '{1'b0, 8'h01, 6'd1,  1'b1, 2};
        vecs[7] = '{1'b1, 8'h55, 6'd5,  1'b1, 6};
        vecs[8] = '{1'b1, 8'h00, 6'd0,  1'b1, 1};
        vecs[9] = '{1'b1, 8'hAA, 6'd0,  1'b0, 64};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", 32'(a_s_ready), 32'd1);
        chk("rst_m_valid", 32'(a_m_valid), 32'd0);
        chk("rst_m_found", 32'(a_m_found), 32'd0);
        chk("rst_m_addr",  32'(a_m_addr),  32'(NF_A));
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_search(vecs[i].sel_b, vecs[i].key, vecs[i].ea, vecs[i].ef, vecs[i].el, 1'b0, 1'b1);
        end

        // Back-pressure: result held stable while m_ready is low.
        m_ready = 1'b0;
        do_search(1'b0, 8'h10, 6'd16, 1'b1, 17, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold_m_valid", 32'(a_m_valid), 32'd1);
            chk("hold_m_addr",  32'(a_m_addr),  32'd16);
            chk("hold_m_found", 32'(a_m_found), 32'd1);
            chk("hold_s_ready", 32'(a_s_ready), 32'd0);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_m_valid", 32'(a_m_valid), 32'd0);
        chk("release_s_ready", 32'(a_s_ready), 32'd1);

        // Reset in the middle of a scan discards the search.
        s_data    = 8'h30;
        s_valid_a = 1'b1;
        @(posedge clk);
        #1;
        s_valid_a = 1'b0;
        chk("abort_busy", 32'(a_s_ready), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_s_ready", 32'(a_s_ready), 32'd1);
        chk("abort_m_valid", 32'(a_m_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (a_m_valid) seen = 1'b1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        do_search(1'b0, 8'h07, 6'd7, 1'b1, 8, 1'b0, 1'b1);

        // Random keys with cke randomly low; latency counted in enabled edges.
        for (int i = 0; i < 1024; i++) begin
            if ($urandom_range(0, 7) == 0) k = 8'($urandom_range(64, 255));
            else                           k = 8'($urandom_range(0, 63));
            if (k < 8'd64) do_search(1'b0, k, k[5:0], 1'b1, int'(k) + 1, 1'b1, 1'b1);
            else           do_search(1'b0, k, NF_A,   1'b0, 64,          1'b1, 1'b1);
        end
        cke = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
